// File: rtl/prio_arbiter_n_if.sv
// Request/grant bundle for prio_arbiter_n.
// The slave side is the arbiter. The master side drives the requests and consumes the grant.
interface prio_arbiter_n_if #(
    parameter int N = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           rr_en;
    logic           grant_ready;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   grant_onehot;
    logic           error;

    modport master (
        output req, rr_en, grant_ready,
        input  grant_valid, grant_id, grant_onehot, error
    );

    modport slave (
        input  req, rr_en, grant_ready,
        output grant_valid, grant_id, grant_onehot, error
    );
endinterface

// File: rtl/prio_arbiter_n.sv
// N-way registered priority arbiter with a valid/ready grant.
// It runs in fixed-priority mode (highest index wins) or in round-robin mode.
// In round-robin mode the search runs descending from ptr and wraps around.

// Per-requester qualifier: is this request at or below the search pointer?
module prio_arbiter_n_lane #(
    parameter int IDW = 3,
    parameter int IDX = 0
) (
    input  logic [IDW-1:0] ptr,
    input  logic           req_bit,
    output logic           hi_bit
);
    assign hi_bit = req_bit && (IDW'(IDX) <= ptr);
endmodule

module prio_arbiter_n #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    prio_arbiter_n_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam logic [IDW-1:0] TOP = IDW'(N - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, ptr_eff;
    logic [IDW-1:0] id_q, id_d, win_id;
    logic [N-1:0]   oh_q, oh_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;
    logic           accept;
    logic           decide;
    logic [N-1:0]   req_hi;

    // Highest set index of a vector. An all-zero vector is never looked at, because callers check it first.
    function automatic logic [IDW-1:0] hi_idx(input logic [N-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) r = IDW'(i);
        return r;
    endfunction

    assign accept = vld_q && bus.grant_ready;

    // Pointer as seen by this cycle's decision.
    // On an acceptance in round-robin mode, the accepted id drops to lowest priority immediately.
    // This lets a back-to-back grant rotate without a bubble.
    always_comb begin
        ptr_eff = ptr_q;
        if (accept && bus.rr_en)
            ptr_eff = (id_q == '0) ? TOP : id_q - 1'b1;
    end

    // The round-robin search is split in two: requests at or below ptr first, then the wrap-around.
    // The highest qualified index wins inside each half.
    for (genvar g = 0; g < N; g++) begin : g_lane
        prio_arbiter_n_lane #(.IDW(IDW), .IDX(g)) u_lane (
            .ptr     (ptr_eff),
            .req_bit (bus.req[g]),
            .hi_bit  (req_hi[g])
        );
    end

    // Winner selection: the masked search when round-robin finds a hit, otherwise plain highest index.
    always_comb begin
        win_id = hi_idx(bus.req);
        if (bus.rr_en && (|req_hi))
            win_id = hi_idx(req_hi);
    end

    // Next-state and next-output logic. Every output holds unless a decision is made.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        oh_d    = oh_q;
        vld_d   = vld_q;
        err_d   = err_q;
        decide  = 1'b0;

        case (state_q)
            IDLE:    decide = 1'b1;
            GRANT:   decide = accept;
            default: decide = 1'b0;
        endcase

        if (decide) begin
            ptr_d = ptr_eff;
            if (|bus.req) begin
                state_d = GRANT;
                vld_d   = 1'b1;
                id_d    = win_id;
                err_d   = 1'b0;
                for (int i = 0; i < N; i++)
                    oh_d[i] = (win_id == IDW'(i));
            end else begin
                // No requester: drop the grant.
                // grant_id keeps its last value for observability.
                state_d = IDLE;
                vld_d   = 1'b0;
                oh_d    = '0;
                err_d   = 1'b1;
            end
        end
    end

    // State and output registers. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= TOP;
            id_q    <= '0;
            oh_q    <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.grant_valid  = vld_q;
    assign bus.grant_id     = id_q;
    assign bus.grant_onehot = oh_q;
    assign bus.error        = err_q;
endmodule

// File: tb/tb_prio_arbiter_n.sv
// Directed and scoreboarded bench for prio_arbiter_n.
// One instance uses N=4 and one uses N=8.
module tb_prio_arbiter_n;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prio_arbiter_n_if #(.N(4)) b4 ();
    prio_arbiter_n_if #(.N(8)) b8 ();

    prio_arbiter_n #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    prio_arbiter_n #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic v, input int id, input logic [3:0] oh, input logic e);
        chk({tag, ".valid"},  b4.grant_valid,  v);
        chk({tag, ".id"},     b4.grant_id,     id);
        chk({tag, ".onehot"}, b4.grant_onehot, oh);
        chk({tag, ".error"},  b4.error,        e);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference pick: walk down from p with wrap-around. Fixed mode starts at the top.
    function automatic int model_pick(input logic [7:0] r, input int p, input bit rr);
        int start;
        start = rr ? p : 7;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start - k + 8) % 8;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    int  m_ptr, m_id;
    bit  m_vld, m_err;

    initial begin
        int seq [6];
        seq = '{3, 2, 1, 0, 3, 2};

        rst = 1'b1;
        b4.req = '0; b4.rr_en = 1'b0; b4.grant_ready = 1'b0;
        b8.req = '0; b8.rr_en = 1'b0; b8.grant_ready = 1'b0;
        tick();
        chk4("reset", 1'b0, 0, 4'b0000, 1'b0);
        rst = 1'b0;

        // Fixed priority: 0110 -> id 2. The same requester is re-granted back-to-back.
        b4.req = 4'b0110; b4.grant_ready = 1'b1;
        tick();
        chk4("fixed", 1'b1, 2, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("fixed_hold", 1'b1, 2, 4'b0100, 1'b0);
        end

        // Round-robin rotation with all requesting. There are no bubbles.
        rst_pulse();
        b4.rr_en = 1'b1; b4.req = 4'b1111; b4.grant_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk4("rr_rot", 1'b1, seq[i], 4'(1 << seq[i]), 1'b0);
        end

        // Reset mid-grant: the grant drops and the pointer returns to the top.
        rst = 1'b1;
        tick();
        chk4("rst_mid", 1'b0, 0, 4'b0000, 1'b0);
        rst = 1'b0;
        tick();
        chk4("rst_ptr", 1'b1, 3, 4'b1000, 1'b0);

        // Stall with 1010: id 3 is held. After acceptance the grant goes to 1, then back to 3.
        rst_pulse();
        b4.req = 4'b1010; b4.grant_ready = 1'b0;
        tick();
        chk4("stall_first", 1'b1, 3, 4'b1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk4("stall_hold", 1'b1, 3, 4'b1000, 1'b0);
        end
        b4.grant_ready = 1'b1;
        tick();
        chk4("stall_acc1", 1'b1, 1, 4'b0010, 1'b0);
        tick();
        chk4("stall_acc2", 1'b1, 3, 4'b1000, 1'b0);
        // req[3] drops during the stall. The grant is not revoked.
        b4.grant_ready = 1'b0; b4.req = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk4("drop_hold", 1'b1, 3, 4'b1000, 1'b0);
        end
        b4.grant_ready = 1'b1;
        tick();
        chk4("drop_acc", 1'b1, 1, 4'b0010, 1'b0);

        // Idle with no requests: error rises and ready is ignored while invalid.
        rst_pulse();
        b4.rr_en = 1'b0; b4.req = 4'b0000; b4.grant_ready = 1'b1;
        tick();
        chk4("empty1", 1'b0, 0, 4'b0000, 1'b1);
        tick();
        chk4("empty2", 1'b0, 0, 4'b0000, 1'b1);
        b4.req = 4'b0001; b4.grant_ready = 1'b0;
        tick();
        chk4("one_req", 1'b1, 0, 4'b0001, 1'b0);
        b4.req = 4'b0000; b4.grant_ready = 1'b1;
        tick();
        chk4("acc_empty", 1'b0, 0, 4'b0000, 1'b1);
        // grant_id survives the drop to invalid.
        b4.req = 4'b0100; b4.grant_ready = 1'b0;
        tick();
        chk4("id2", 1'b1, 2, 4'b0100, 1'b0);
        b4.req = 4'b0000; b4.grant_ready = 1'b1;
        tick();
        chk4("id_keep", 1'b0, 2, 4'b0000, 1'b1);

        // rr_en toggled during a held grant only affects the next decision.
        rst_pulse();
        b4.rr_en = 1'b1; b4.req = 4'b1001; b4.grant_ready = 1'b0;
        tick();
        chk4("tog_first", 1'b1, 3, 4'b1000, 1'b0);
        b4.rr_en = 1'b0;
        tick();
        chk4("tog_hold", 1'b1, 3, 4'b1000, 1'b0);
        b4.grant_ready = 1'b1;
        tick();
        chk4("tog_fixed", 1'b1, 3, 4'b1000, 1'b0);

        // N=8 scoreboard run.
        b4.req = '0; b4.grant_ready = 1'b0;
        rst_pulse();
        m_ptr = 7; m_id = 0; m_vld = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            logic [7:0] r;
            bit rdy, rr, stall;
            int pid, w;
            r   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rdy = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 3) != 0);
            b8.req = r; b8.grant_ready = rdy; b8.rr_en = rr;
            stall = m_vld && !rdy;
            pid   = m_id;
            if (!m_vld || rdy) begin
                if (m_vld && rr) m_ptr = (m_id == 0) ? 7 : m_id - 1;
                w = model_pick(r, m_ptr, rr);
                if (w < 0) begin
                    m_vld = 1'b0; m_err = 1'b1;
                end else begin
                    m_vld = 1'b1; m_err = 1'b0; m_id = w;
                end
            end
            tick();
            $display("t=%0t req=%b grant_id=%0d error=%b", $time, r, b8.grant_id, b8.error);
            chk("sb.valid", b8.grant_valid, m_vld);
            chk("sb.id",    b8.grant_id,    m_id);
            chk("sb.onehot", b8.grant_onehot, m_vld ? (32'd1 << m_id) : 32'd0);
            chk("sb.error", b8.error,       m_err);
            if (stall) chk("sb.stall", b8.grant_id, pid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
